mac_result_collector: RTL and testbench

// - Downstream of the MAC term controller. Captures each accumulator result on its load_result pulse,

---
 rtl/mac_result_collector_if.sv | 24 ++
 rtl/mac_result_collector.sv | 123 ++++++++++++
 tb/tb_mac_result_collector.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_result_collector_if.sv
// Output sample stream of the MAC result collector.
// Valid/ready handshake carrying a scaled sample and its frame-last flag.
interface mac_result_collector_if #(
  parameter int OUT_W = 16
);
  logic             valid;
  logic             ready;
  logic [OUT_W-1:0] data;
  logic             last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/mac_result_collector.sv
// Captures MAC results, rescales with saturation and buffers them in a FIFO.
// Optional RESULT_ROUND_EN: round half up before the shift instead of floor.
module mac_result_collector #(
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_result_i,
  input  logic [ACC_W-1:0]         result_i,
  input  logic                     last_i,
  input  logic                     clr_stats_i,
  mac_result_collector_if.master   m,
  output logic                     frame_done_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_count_o,
  output logic [7:0]               sat_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [ACC_W:0] MAXV =
    $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] MINV =
    $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
`ifdef RESULT_ROUND_EN
  localparam logic signed [ACC_W:0] HALF =
    (ACC_W+1)'(1) <<< (FRAC_SHIFT-1);
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] shf;
  logic                  clip_hi;
  logic                  clip_lo;
  logic [OUT_W-1:0]      scaled;

  logic                  stage_vld;
  logic [OUT_W-1:0]      stage_data;
  logic                  stage_last;

  logic [OUT_W:0]        mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [OUT_W:0]        head;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    ext = $signed({result_i[ACC_W-1], result_i});
`ifdef RESULT_ROUND_EN
    ext = ext + HALF;
`endif
    shf     = ext >>> FRAC_SHIFT;
    clip_hi = shf > MAXV;
    clip_lo = shf < MINV;
    scaled  = shf[OUT_W-1:0];
    if (clip_hi) scaled = MAXV[OUT_W-1:0];
    if (clip_lo) scaled = MINV[OUT_W-1:0];
  end

  assign empty_o = count == '0;
  assign full_o  = count == FULL_CNT;
  assign count_o = count;

  assign pop  = !empty_o && m.ready && !rst_i;
  assign push = stage_vld && (!full_o || pop);
  assign drop = stage_vld && !push;

  // Head is masked while empty so reset leaves the bus at zero.
  assign head         = empty_o ? '0 : mem[rd_ptr];
  assign m.valid      = !empty_o;
  assign m.data       = head[OUT_W-1:0];
  assign m.last       = head[OUT_W];
  assign frame_done_o = pop && head[OUT_W];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {stage_last, stage_data};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_vld    <= 1'b0;
      stage_data   <= '0;
      stage_last   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
      sat_count_o  <= '0;
    end else begin
      stage_vld <= load_result_i;
      if (load_result_i) begin
        stage_data <= scaled;
        stage_last <= last_i;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (clr_stats_i) begin
        overflow_o   <= 1'b0;
        drop_count_o <= '0;
        sat_count_o  <= '0;
      end else begin
        if (drop) begin
          overflow_o <= 1'b1;
          if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 1'b1;
        end
        if (load_result_i && (clip_hi || clip_lo) && sat_count_o != 8'hFF)
          sat_count_o <= sat_count_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector with default parameters.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_mac_result_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] result;
  logic        last;
  logic        clr;
  logic        frame_done;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [7:0]  sat_count;
  int          checks = 0;
  int          fails  = 0;

  mac_result_collector_if #(.OUT_W(16)) mif ();

  mac_result_collector dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .load_result_i (load),
    .result_i      (result),
    .last_i        (last),
    .clr_stats_i   (clr),
    .m             (mif),
    .frame_done_o  (frame_done),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty),
    .overflow_o    (overflow),
    .drop_count_o  (drop_count),
    .sat_count_o   (sat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_one(logic [31:0] v, logic l);
    load = 1'b1; result = v; last = l;
    tick();
    load = 1'b0; last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; result = '0; last = 1'b0; clr = 1'b0;
    mif.ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_valid", mif.valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_data", mif.data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sat", sat_count, 0);
  endtask

  task automatic test_latency();
    push_one(32'h0000_0300, 1'b0);
    chk("lat_c1_valid", mif.valid, 0);
    tick();
    chk("lat_c2_valid", mif.valid, 1);
    chk("lat_c2_data", mif.data, 16'h0003);
    mif.ready = 1'b1;
    tick();
    mif.ready = 1'b0;
    chk("lat_c3_empty", empty, 1);
  endtask

  task automatic test_rounding();
    logic [15:0] e0, e1;
`ifdef RESULT_ROUND_EN
    e0 = 16'h0002; e1 = 16'hFFFF;
`else
    e0 = 16'h0001; e1 = 16'hFFFE;
`endif
    push_one(32'h0000_0180, 1'b0);
    push_one(32'hFFFF_FE80, 1'b0);
    tick();
    chk("rnd_count", count, 2);
    mif.ready = 1'b1;
    #1;
    chk("rnd_pos", mif.data, e0);
    tick();
    chk("rnd_neg", mif.data, e1);
    tick();
    mif.ready = 1'b0;
    chk("rnd_empty", empty, 1);
  endtask

  task automatic test_saturation();
    push_one(32'h7FFF_FFFF, 1'b0);
    push_one(32'h8000_0000, 1'b0);
    tick();
    chk("sat_count", sat_count, 2);
    mif.ready = 1'b1;
    #1;
    chk("sat_hi", mif.data, 16'h7FFF);
    tick();
    chk("sat_lo", mif.data, 16'h8000);
    tick();
    mif.ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sat_clr", sat_count, 0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) push_one(32'(i) << 8, 1'b0);
    tick();
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 1);
    mif.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("ovf_order", mif.data, 32'(i));
      tick();
    end
    mif.ready = 1'b0;
    chk("ovf_drained", empty, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    chk("ovf_clr_cnt", drop_count, 0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 10; i <= 17; i++) push_one(32'(i) << 8, 1'b0);
    tick();
    chk("fpp_full", full, 1);
    push_one(32'(18) << 8, 1'b0);
    mif.ready = 1'b1;
    #1;
    chk("fpp_head", mif.data, 10);
    tick();
    mif.ready = 1'b0;
    chk("fpp_count", count, 8);
    chk("fpp_drops", drop_count, 0);
    chk("fpp_ovf", overflow, 0);
    mif.ready = 1'b1;
    for (int i = 11; i <= 18; i++) begin
      #1;
      chk("fpp_order", mif.data, 32'(i));
      tick();
    end
    mif.ready = 1'b0;
    chk("fpp_empty", empty, 1);
  endtask

  task automatic test_frame_backpressure();
    int          fd;
    int          pops;
    logic        stalled;
    logic [15:0] held;
    fd = 0; pops = 0; stalled = 1'b0; held = '0;
    push_one(32'h0000_0100, 1'b0);
    push_one(32'h0000_0200, 1'b0);
    push_one(32'h0000_0300, 1'b1);
    tick();
    for (int c = 0; c < 12; c++) begin
      mif.ready = c[0];
      #1;
      if (stalled) chk("bp_stable", mif.data, held);
      if (mif.valid && mif.ready) begin
        pops++;
        chk("bp_order", mif.data, 32'(pops));
        chk("bp_last", mif.last, pops == 3);
      end
      if (frame_done) begin
        fd++;
        chk("bp_fd_data", mif.data, 3);
      end
      stalled = mif.valid && !mif.ready;
      held = mif.data;
      tick();
    end
    mif.ready = 1'b0;
    chk("bp_fd_once", fd, 1);
    chk("bp_pops", pops, 3);
    chk("bp_empty", empty, 1);
  endtask

  task automatic test_back_to_back();
    mif.ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      load = c < 5;
      result = 32'(c + 1) << 8;
      #1;
      if (c >= 2 && c < 7) begin
        chk("b2b_valid", mif.valid, 1);
        chk("b2b_data", mif.data, 32'(c - 1));
        chk("b2b_count", count, 1);
      end
      tick();
    end
    load = 1'b0;
    mif.ready = 1'b0;
    chk("b2b_empty", empty, 1);
  endtask

  task automatic test_reset_mid();
    push_one(32'h7FFF_FFFF, 1'b0);
    push_one(32'h0000_0100, 1'b0);
    load = 1'b1; result = 32'h0000_0200;
    rst = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0;
    chk("mrst_empty", empty, 1);
    chk("mrst_valid", mif.valid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_sat", sat_count, 0);
    chk("mrst_drops", drop_count, 0);
    chk("mrst_ovf", overflow, 0);
    tick();
    tick();
    chk("mrst_stage_gone", empty, 1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_frame_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
